// File: rtl/mar_mem_port.sv
// Memory address register with a single-outstanding req/ack memory port.
// Address loads/increments in IDLE; ACCESS freezes the port until ack or timeout.
module mar_mem_port #(
  parameter int unsigned AW       = 4,
  parameter int unsigned DW       = 8,
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned AUTO_INC = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          IMR,
  input  logic          INC,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  output logic [AW-1:0] ABUS,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          err_clr
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ABUS      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      // A timeout later in this block overrides the clear, so set wins.
      if (err_clr) err <= 1'b0;

      case (state)
        IDLE: begin
          if (!IMR)     ABUS <= addr;
          else if (INC) ABUS <= ABUS + 1'b1;

          if (rd || wr) begin
            state   <= ACCESS;
            mem_req <= 1'b1;
            busy    <= 1'b1;
            mem_we  <= wr & ~rd;
            cnt     <= '0;
            if (wr && !rd) mem_wdata <= wdata;
          end
        end

        ACCESS: begin
          if (mem_ack) begin
            if (!mem_we) rdata <= mem_rdata;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
            if (AUTO_INC != 0) ABUS <= ABUS + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == TO_LAST) begin
              mem_req <= 1'b0;
              busy    <= 1'b0;
              err     <= 1'b1;
              state   <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mar_mem_port.sv
// Directed bench for mar_mem_port (TIMEOUT=4, AUTO_INC=1) with a completion scoreboard.
module tb_mar_mem_port;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       IMR = 1'b1;
  logic       INC = 1'b0;
  logic [3:0] addr = '0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wdata = '0;
  logic [3:0] ABUS;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       mem_ack = 1'b0;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       err;
  logic       err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] rdata;
    logic [3:0] abus;
  } exp_t;

  exp_t exp_q[$];

  mar_mem_port #(.AW(4), .DW(8), .TIMEOUT(4), .AUTO_INC(1)) dut (
    .clk(clk), .rst_n(rst_n), .IMR(IMR), .INC(INC), .addr(addr),
    .rd(rd), .wr(wr), .wdata(wdata), .ABUS(ABUS), .mem_req(mem_req),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .rdata(rdata), .busy(busy), .done(done),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse or err rising edge consumes one scoreboard entry.
  logic prev_err = 1'b0;
  always @(negedge clk) begin
    if (rst_n && (done || (err && !prev_err))) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: got done=%0b err=%0b expected none", done, err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("completion_kind", {30'd0, err && !prev_err, done}, e.is_err ? 32'h2 : 32'h1);
        chk("completion_rdata", 32'(rdata), 32'(e.rdata));
        chk("completion_abus", 32'(ABUS), 32'(e.abus));
      end
    end
    prev_err = err;
  end

  // Starts a transaction from IDLE; ack on the ack_cyc-th mem_req cycle (0 = never).
  task automatic txn(input bit w, input logic [7:0] wd, input int ack_cyc,
                     input logic [7:0] rv, input bit toggle, input int exp_cycles,
                     input string name);
    int cycles;
    logic [3:0] abus0;
    rd = !w; wr = w; wdata = wd;
    step();
    rd = 1'b0; wr = 1'b0;
    abus0 = ABUS;
    chk({name, "_busy"}, 32'(busy), 32'h1);
    cycles = 0;
    while (mem_req && cycles < 20) begin
      cycles++;
      if (w) begin
        chk({name, "_we"}, 32'(mem_we), 32'h1);
        chk({name, "_wdata"}, 32'(mem_wdata), 32'(wd));
        chk({name, "_abus_frozen"}, 32'(ABUS), 32'(abus0));
      end
      if (cycles == ack_cyc) begin
        mem_ack = 1'b1;
        mem_rdata = rv;
      end
      if (toggle) begin
        IMR = 1'b0; addr = 4'hE; INC = 1'b1; rd = 1'b1;
      end
      step();
      mem_ack = 1'b0; IMR = 1'b1; INC = 1'b0; rd = 1'b0;
    end
    chk({name, "_req_cycles"}, 32'(cycles), 32'(exp_cycles));
    chk({name, "_busy_end"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step();
    rst_n = 1'b1;
    IMR = 1'b0; addr = 4'h7;
    step();
    IMR = 1'b1;
    chk("pre_reset_load", 32'(ABUS), 32'h7);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", {18'd0, ABUS, mem_req, mem_we, busy, done, err},
        32'h0);
    chk("reset_data", {8'd0, mem_wdata, rdata, 8'd0}, 32'h0);
    step();
    rst_n = 1'b1;

    IMR = 1'b0; addr = 4'hA;
    step();
    chk("load_A", 32'(ABUS), 32'hA);
    IMR = 1'b0; INC = 1'b1; addr = 4'h3;
    step();
    chk("load_beats_inc", 32'(ABUS), 32'h3);
    INC = 1'b0; addr = 4'hF;
    step();
    IMR = 1'b1; INC = 1'b1;
    step();
    INC = 1'b0;
    chk("inc_wrap", 32'(ABUS), 32'h0);

    // Read at 5, ack on 3rd cycle
    IMR = 1'b0; addr = 4'h5;
    step();
    IMR = 1'b1;
    exp_q.push_back('{1'b0, 8'h3C, 4'h6});
    txn(1'b0, 8'h00, 3, 8'h3C, 1'b0, 3, "read");
    chk("read_done_pulse", 32'(done), 32'h1);
    step();
    chk("done_one_cycle", 32'(done), 32'h0);

    // Write while IMR/INC/rd toggle; none must take effect
    exp_q.push_back('{1'b0, 8'h3C, 4'h7});
    txn(1'b1, 8'h81, 2, 8'hFF, 1'b1, 2, "write");
    step();
    chk("no_extra_txn", 32'(mem_req), 32'h0);

    // Timeout: no ack
    exp_q.push_back('{1'b1, 8'h3C, 4'h7});
    txn(1'b0, 8'h00, 0, 8'h00, 1'b0, 4, "timeout");
    chk("timeout_err", 32'(err), 32'h1);
    chk("timeout_no_done", 32'(done), 32'h0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared", 32'(err), 32'h0);

    // Minimum-length read, then ack on the expiry cycle
    exp_q.push_back('{1'b0, 8'h5A, 4'h8});
    txn(1'b0, 8'h00, 1, 8'h5A, 1'b0, 1, "min_read");
    step();
    exp_q.push_back('{1'b0, 8'hC3, 4'h9});
    txn(1'b0, 8'h00, 4, 8'hC3, 1'b0, 4, "ack_at_expiry");
    chk("expiry_no_err", 32'(err), 32'h0);

    // Back-to-back: second start sampled on the done cycle's edge
    exp_q.push_back('{1'b0, 8'h11, 4'hA});
    txn(1'b0, 8'h00, 2, 8'h11, 1'b0, 2, "b2b_first");
    exp_q.push_back('{1'b0, 8'h22, 4'hB});
    txn(1'b0, 8'h00, 1, 8'h22, 1'b0, 1, "b2b_second");
    step();

    // Reset during ACCESS aborts with no done
    rd = 1'b1;
    step();
    rd = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_access_req", 32'(mem_req), 32'h0);
    chk("rst_access_busy", 32'(busy), 32'h0);
    chk("rst_access_rdata", 32'(rdata), 32'h0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("rst_access_idle", {30'd0, mem_req, done}, 32'h0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
